gold_seq_gen: RTL and testbench

Pseudo-random Gold sequence generator c(n) for the PUSCH scrambling stage, using the 3GPP TS 38.211 §5.2.1 length-31 Gold sequence with Nc = 1600. Sits directly upstream of the scrambler and drives its Gold_IN and GOLD_VALID inputs. Runs the 1600-step warm-up after each START. Then advances one bit per scrambler consumption until SEQ_LEN bits have been delivered.

---
 rtl/pusch_pkg.sv | 18 +
 rtl/gold_seq_gen_if.sv | 26 ++
 rtl/gold_lfsr_step.sv | 15 +
 rtl/gold_seq_gen.sv | 114 +++++++++++
 tb/tb_gold_seq_gen.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pusch_pkg.sv
// Shared constants and types for the PUSCH Gold sequence generator (TS 38.211 length-31 Gold code).
package pusch_pkg;

    localparam int              NC_DEFAULT = 1600;
    localparam int              GOLD_W     = 31;
    localparam logic [GOLD_W-1:0] X1_INIT  = 31'h1;

    // Feedback taps: x1 uses x(n+3)+x(n), x2 uses x(n+3)+x(n+2)+x(n+1)+x(n).
    localparam logic [GOLD_W-1:0] X1_TAPS  = 31'h0000_0009;
    localparam logic [GOLD_W-1:0] X2_TAPS  = 31'h0000_000F;

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        RUN
    } gold_state_t;

endpackage

// File: rtl/gold_seq_gen_if.sv
// Handshake bundle between the sequence requester, the Gold generator and the scrambler.
interface gold_seq_gen_if #(
    parameter int LEN_W = 16
);
    import pusch_pkg::*;

    logic              START;
    logic [GOLD_W-1:0] C_INIT;
    logic [LEN_W-1:0]  SEQ_LEN;
    logic              ADV;
    logic              GOLD_OUT;
    logic              GOLD_VALID;
    logic              GEN_BUSY;
    logic              DONE;

    modport master (
        output START, C_INIT, SEQ_LEN, ADV,
        input  GOLD_OUT, GOLD_VALID, GEN_BUSY, DONE
    );

    modport slave (
        input  START, C_INIT, SEQ_LEN, ADV,
        output GOLD_OUT, GOLD_VALID, GEN_BUSY, DONE
    );

endinterface

// File: rtl/gold_lfsr_step.sv
// One combinational advance of both Gold m-sequence registers (bit i holds x(n+i)).
module gold_lfsr_step
    import pusch_pkg::*;
(
    input  logic [GOLD_W-1:0] x1,
    input  logic [GOLD_W-1:0] x2,
    output logic [GOLD_W-1:0] next_x1,
    output logic [GOLD_W-1:0] next_x2
);

    // The new element x(n+31) enters at the top as everything shifts toward bit 0.
    assign next_x1 = {^(x1 & X1_TAPS), x1[GOLD_W-1:1]};
    assign next_x2 = {^(x2 & X2_TAPS), x2[GOLD_W-1:1]};

endmodule

// File: rtl/gold_seq_gen.sv
// Gold sequence generator feeding the PUSCH scrambler: NC-step warm-up, then one bit per ADV.
// Define GOLD_PARALLEL_WARMUP_EN to warm up four steps per cycle (output sequence unchanged).
module gold_seq_gen
    import pusch_pkg::*;
#(
    parameter int LEN_W = 16,
    parameter int NC    = NC_DEFAULT
)(
    input  logic           CLK_SC,
    input  logic           RST_SC,
    gold_seq_gen_if.slave  bus
);

`ifdef GOLD_PARALLEL_WARMUP_EN
    localparam int WARM_STEPS = 4;
`else
    localparam int WARM_STEPS = 1;
`endif

    localparam logic [10:0] WARM_LAST = 11'(NC - WARM_STEPS);
    localparam logic [10:0] WARM_INC  = 11'(WARM_STEPS);

    gold_state_t       state;
    logic [GOLD_W-1:0] x1;
    logic [GOLD_W-1:0] x2;
    logic [10:0]       warm_cnt;
    logic [LEN_W-1:0]  bit_cnt;
    logic [LEN_W-1:0]  len_q;
    logic              gold_out;
    logic              gold_valid;
    logic              gen_busy;
    logic              done;

    logic [GOLD_W-1:0] chain_x1 [0:WARM_STEPS];
    logic [GOLD_W-1:0] chain_x2 [0:WARM_STEPS];

    assign chain_x1[0] = x1;
    assign chain_x2[0] = x2;

    // Tap 1 of the chain is a single step (RUN); the last tap is a full warm-up cycle.
    for (genvar g = 0; g < WARM_STEPS; g++) begin : g_step
        gold_lfsr_step u_step (
            .x1      (chain_x1[g]),
            .x2      (chain_x2[g]),
            .next_x1 (chain_x1[g+1]),
            .next_x2 (chain_x2[g+1])
        );
    end

    always_ff @(posedge CLK_SC or negedge RST_SC) begin
        if (!RST_SC) begin
            state      <= IDLE;
            x1         <= '0;
            x2         <= '0;
            warm_cnt   <= '0;
            bit_cnt    <= '0;
            len_q      <= '0;
            gold_out   <= 1'b0;
            gold_valid <= 1'b0;
            gen_busy   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.START && (bus.SEQ_LEN != '0)) begin
                        x1       <= X1_INIT;
                        x2       <= bus.C_INIT;
                        len_q    <= bus.SEQ_LEN;
                        warm_cnt <= '0;
                        bit_cnt  <= '0;
                        gen_busy <= 1'b1;
                        state    <= WARMUP;
                    end
                end
                WARMUP: begin
                    x1 <= chain_x1[WARM_STEPS];
                    x2 <= chain_x2[WARM_STEPS];
                    if (warm_cnt == WARM_LAST) begin
                        state      <= RUN;
                        gold_valid <= 1'b1;
                        gold_out   <= chain_x1[WARM_STEPS][0] ^ chain_x2[WARM_STEPS][0];
                    end else begin
                        warm_cnt <= warm_cnt + WARM_INC;
                    end
                end
                RUN: begin
                    // The output bit is registered from the post-step state, so it never depends on ADV combinationally.
                    if (bus.ADV) begin
                        x1      <= chain_x1[1];
                        x2      <= chain_x2[1];
                        bit_cnt <= bit_cnt + LEN_W'(1);
                        if (bit_cnt == len_q - LEN_W'(1)) begin
                            state      <= IDLE;
                            gold_valid <= 1'b0;
                            gold_out   <= 1'b0;
                            gen_busy   <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            gold_out <= chain_x1[1][0] ^ chain_x2[1][0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.GOLD_OUT   = gold_out;
    assign bus.GOLD_VALID = gold_valid;
    assign bus.GEN_BUSY   = gen_busy;
    assign bus.DONE       = done;

endmodule

// File: tb/tb_gold_seq_gen.sv
// Self-checking bench for gold_seq_gen: array-based Gold reference plus a per-cycle output compare.
module tb_gold_seq_gen;

    localparam int NC = 1600;
`ifdef GOLD_PARALLEL_WARMUP_EN
    localparam int NC_CYC = NC / 4;
`else
    localparam int NC_CYC = NC;
`endif

    logic CLK_SC = 1'b0;
    logic RST_SC = 1'b0;

    gold_seq_gen_if #(.LEN_W(16)) bus ();

    gold_seq_gen #(.LEN_W(16), .NC(NC)) dut (
        .CLK_SC (CLK_SC),
        .RST_SC (RST_SC),
        .bus    (bus)
    );

    always #5 CLK_SC = ~CLK_SC;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    bit m_busy  = 1'b0;
    bit m_done  = 1'b0;
    int m_warm  = 0;
    int m_deliv = 0;
    int m_len   = 0;
    bit exp_q[$];

    // c(n) straight from the recurrence definitions, expanded as plain bit arrays.
    function automatic bit ref_bit(input bit [30:0] ci, input int nc, input int n);
        bit a1[];
        bit a2[];
        int tot;
        tot = n + nc + 1;
        if (tot < 31) tot = 31;
        a1 = new[tot];
        a2 = new[tot];
        for (int i = 0; i < 31; i++) begin
            a1[i] = (i == 0);
            a2[i] = ci[i];
        end
        for (int m = 31; m < tot; m++) begin
            a1[m] = a1[m-28] ^ a1[m-31];
            a2[m] = a2[m-28] ^ a2[m-29] ^ a2[m-30] ^ a2[m-31];
        end
        return a1[n+nc] ^ a2[n+nc];
    endfunction

    task automatic check_output(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0b expected=%0b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_count(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference timeline: what must be visible after each clock edge.
    always @(posedge CLK_SC or negedge RST_SC) begin
        if (!RST_SC) begin
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_warm  = 0;
            m_deliv = 0;
            m_len   = 0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (bus.START && bus.SEQ_LEN != 0) begin
                    m_busy  = 1'b1;
                    m_warm  = NC_CYC;
                    m_deliv = 0;
                    m_len   = int'(bus.SEQ_LEN);
                    exp_q.delete();
                    for (int i = 0; i < m_len; i++) exp_q.push_back(ref_bit(bus.C_INIT, NC, i));
                end
            end else if (m_warm > 0) begin
                m_warm--;
            end else if (bus.ADV) begin
                m_deliv++;
                if (m_deliv == m_len) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    end

    always @(negedge CLK_SC) begin
        logic mv;
        logic mo;
        if (cmp_en) begin
            mv = m_busy && (m_warm == 0);
            mo = (mv && m_deliv < exp_q.size()) ? exp_q[m_deliv] : 1'b0;
            check_output("gold_valid", bus.GOLD_VALID, mv);
            check_output("gold_out", bus.GOLD_OUT, mo);
            check_output("gen_busy", bus.GEN_BUSY, m_busy);
            check_output("done", bus.DONE, m_done);
        end
    end

    task automatic apply_stimulus(input logic s, input logic [30:0] ci, input logic [15:0] len, input logic adv);
        bus.START   = s;
        bus.C_INIT  = ci;
        bus.SEQ_LEN = len;
        bus.ADV     = adv;
        @(posedge CLK_SC);
        #1;
        bus.START = 1'b0;
    endtask

    task automatic tick(input logic adv);
        apply_stimulus(1'b0, 31'($urandom), 16'($urandom), adv);
    endtask

    task automatic wait_valid(input logic adv, input int budget);
        int n = 0;
        while (!bus.GOLD_VALID && n < budget) begin
            tick(adv);
            n++;
        end
        check_output("valid_timeout", bus.GOLD_VALID, 1'b1);
    endtask

    // mode 0: ADV held high; mode 1: random ADV. Returns bits actually consumed.
    task automatic run_until_done(input int mode, input int budget, output int consumed);
        int  n = 0;
        logic adv;
        logic was_valid;
        bit  seen = 1'b0;
        consumed = 0;
        while (!seen && n < budget) begin
            adv       = (mode == 0) ? 1'b1 : 1'($urandom % 2);
            was_valid = bus.GOLD_VALID;
            tick(adv);
            if (was_valid && adv) consumed++;
            if (bus.DONE) seen = 1'b1;
            n++;
        end
        check_output("done_timeout", seen, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_out"},   bus.GOLD_OUT,   1'b0);
        check_output({tag, "_valid"}, bus.GOLD_VALID, 1'b0);
        check_output({tag, "_busy"},  bus.GEN_BUSY,   1'b0);
        check_output({tag, "_done"},  bus.DONE,       1'b0);
    endtask

    initial begin
        int   cyc;
        int   cons;
        logic held;
        logic pat [8];
        logic [30:0] ci;
        int   len;

        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        bus.START   = 1'b0;
        bus.C_INIT  = '0;
        bus.SEQ_LEN = '0;
        bus.ADV     = 1'b0;
        repeat (3) @(posedge CLK_SC);
        #1;
        cmp_en = 1'b1;
        check_all_zero("reset");

        check_output("pin_c0_ci0",  ref_bit(31'h0, 0, 0),  1'b1);
        check_output("pin_c0_ci1",  ref_bit(31'h1, 0, 0),  1'b0);
        check_output("pin_c31_ci0", ref_bit(31'h0, 0, 31), 1'b1);
        check_output("pin_c31_ci1", ref_bit(31'h1, 0, 31), 1'b0);
        check_output("pin_c34_ci0", ref_bit(31'h0, 0, 34), 1'b0);
        check_output("pin_c62_ci0", ref_bit(31'h0, 0, 62), 1'b1);

        RST_SC = 1'b1;
        tick(1'b0);

        $display("[TB] warm-up latency");
        apply_stimulus(1'b1, 31'h0, 16'd8, 1'b1);
        check_output("t1_busy", bus.GEN_BUSY, 1'b1);
        cyc = 0;
        while (!bus.GOLD_VALID && cyc < NC_CYC + 20) begin
            tick(1'b1);
            cyc++;
        end
        check_count("t1_warm_cycles", cyc, NC_CYC);
        run_until_done(0, 100, cons);
        check_count("t1_consumed", cons, 8);

        $display("[TB] 64-bit sequences");
        apply_stimulus(1'b1, 31'h0, 16'd64, 1'b1);
        run_until_done(0, NC_CYC + 200, cons);
        check_count("t2a_consumed", cons, 64);
        apply_stimulus(1'b1, 31'h1234567, 16'd64, 1'b1);
        run_until_done(0, NC_CYC + 200, cons);
        check_count("t2b_consumed", cons, 64);

        $display("[TB] ADV pattern");
        apply_stimulus(1'b1, 31'h55AA33C, 16'd5, 1'b0);
        wait_valid(1'b0, NC_CYC + 20);
        for (int i = 0; i < 8; i++) begin
            held = bus.GOLD_OUT;
            tick(pat[i]);
            if (i < 7) begin
                check_output("t3_done_early", bus.DONE, 1'b0);
                if (!pat[i]) check_output("t3_hold", bus.GOLD_OUT, held);
            end
        end
        check_output("t3_done", bus.DONE, 1'b1);

        $display("[TB] START while busy");
        apply_stimulus(1'b1, 31'h0ABCDEF, 16'd10, 1'b0);
        repeat (100) tick(1'b1);
        apply_stimulus(1'b1, 31'h7FFFFFFF, 16'd3, 1'b1);
        wait_valid(1'b1, NC_CYC + 20);
        repeat (4) tick(1'b1);
        apply_stimulus(1'b1, 31'h1, 16'd2, 1'b1);
        run_until_done(0, 100, cons);
        check_count("t4_consumed", cons, 5);
        apply_stimulus(1'b1, 31'h123, 16'd0, 1'b0);
        check_output("t4_len0_busy", bus.GEN_BUSY, 1'b0);
        repeat (3) tick(1'b0);
        check_output("t4_len0_busy2", bus.GEN_BUSY, 1'b0);
        check_output("t4_len0_done", bus.DONE, 1'b0);

        $display("[TB] reset aborts");
        apply_stimulus(1'b1, 31'h2468ACE, 16'd12, 1'b1);
        repeat (NC_CYC / 2 - 1) tick(1'b1);
        RST_SC = 1'b0;
        #1;
        check_all_zero("t5_rst_warm");
        @(posedge CLK_SC);
        #1;
        RST_SC = 1'b1;
        apply_stimulus(1'b1, 31'h2468ACE, 16'd12, 1'b1);
        wait_valid(1'b1, NC_CYC + 20);
        repeat (3) tick(1'b1);
        RST_SC = 1'b0;
        #1;
        check_all_zero("t5_rst_run");
        @(posedge CLK_SC);
        #1;
        RST_SC = 1'b1;
        tick(1'b0);
        check_all_zero("t5_after");
        apply_stimulus(1'b1, 31'h2468ACE, 16'd12, 1'b1);
        run_until_done(0, NC_CYC + 100, cons);
        check_count("t5_consumed", cons, 12);

        $display("[TB] START in DONE cycle");
        apply_stimulus(1'b1, 31'h0F0F0F0, 16'd6, 1'b1);
        run_until_done(0, NC_CYC + 100, cons);
        check_count("t6a_consumed", cons, 6);
        apply_stimulus(1'b1, 31'h3C3C3C3, 16'd7, 1'b1);
        check_output("t6_restart_busy", bus.GEN_BUSY, 1'b1);
        run_until_done(0, NC_CYC + 100, cons);
        check_count("t6b_consumed", cons, 7);

        $display("[TB] random sequences");
        repeat (4) begin
            ci  = 31'($urandom);
            len = $urandom_range(1, 40);
            apply_stimulus(1'b1, ci, 16'(len), 1'($urandom % 2));
            run_until_done(1, NC_CYC + 400, cons);
            check_count("rand_consumed", cons, len);
        end

        tick(1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
